// File: rtl/id_operand_if.sv
// Bus bundle for the ID-to-EX operand stage.
// The slave side is the operand stage itself. The master side is the surrounding pipeline: decode, RF, EX, MEM and hazard control.
interface id_operand_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
);
  logic              id_valid;
  logic [ADDR_W-1:0] id_rs0_addr;
  logic [ADDR_W-1:0] id_rs1_addr;
  logic              id_rs0_used;
  logic              id_rs1_used;
  logic [ADDR_W-1:0] id_dst_addr;
  logic              id_we;
  logic              id_is_load;
  logic [DATA_W-1:0] rf_p0;
  logic [DATA_W-1:0] rf_p1;
  logic [DATA_W-1:0] ex_result;
  logic [ADDR_W-1:0] mem_dst_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_result;
  logic              stall_in;
  logic              flush;
  logic              rf_re0;
  logic              rf_re1;
  logic              stall_out;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_op0;
  logic [DATA_W-1:0] ex_op1;
  logic [ADDR_W-1:0] ex_dst_addr;
  logic              ex_we;
  logic              ex_is_load;
  logic [CNT_W-1:0]  stall_cnt;

  modport slave (
    input  id_valid, id_rs0_addr, id_rs1_addr, id_rs0_used, id_rs1_used,
           id_dst_addr, id_we, id_is_load, rf_p0, rf_p1, ex_result,
           mem_dst_addr, mem_we, mem_result, stall_in, flush,
    output rf_re0, rf_re1, stall_out, ex_valid, ex_op0, ex_op1,
           ex_dst_addr, ex_we, ex_is_load, stall_cnt
  );

  modport master (
    output id_valid, id_rs0_addr, id_rs1_addr, id_rs0_used, id_rs1_used,
           id_dst_addr, id_we, id_is_load, rf_p0, rf_p1, ex_result,
           mem_dst_addr, mem_we, mem_result, stall_in, flush,
    input  rf_re0, rf_re1, stall_out, ex_valid, ex_op0, ex_op1,
           ex_dst_addr, ex_we, ex_is_load, stall_cnt
  );
endinterface

// File: rtl/id_operand_stage.sv
// Decode-to-execute operand stage.
// It selects each operand from R0 zero, the EX forward, the MEM forward or RF port data.
// A load-use hazard inserts a single bubble. The stage owns the ID/EX register and a saturating bubble counter.
module id_operand_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input logic          clk,
  input logic          rst,
  id_operand_if.slave  bus
);

  logic              ex_valid_q,   ex_valid_d;
  logic              ex_we_q,      ex_we_d;
  logic              ex_is_load_q, ex_is_load_d;
  logic [DATA_W-1:0] ex_op0_q,     ex_op0_d;
  logic [DATA_W-1:0] ex_op1_q,     ex_op1_d;
  logic [ADDR_W-1:0] ex_dst_q,     ex_dst_d;
  logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;

  logic              ex_fwd_ok;
  logic              hz;
  logic [DATA_W-1:0] op0_sel;
  logic [DATA_W-1:0] op1_sel;

  // Operand priority: R0 is zero, then a non-load EX result, then the MEM write value, then the RF port.
  // A load still in EX has no data yet, so it is never forwarded from EX.
  function automatic logic [DATA_W-1:0] select_operand(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] rf_data,
    input logic              ex_ok,
    input logic [ADDR_W-1:0] ex_dst,
    input logic [DATA_W-1:0] ex_res,
    input logic              mem_wr,
    input logic [ADDR_W-1:0] mem_dst,
    input logic [DATA_W-1:0] mem_res
  );
    if (addr == '0)                     return '0;
    else if (ex_ok && addr == ex_dst)   return ex_res;
    else if (mem_wr && addr == mem_dst) return mem_res;
    else                                return rf_data;
  endfunction

  // The counter saturates and never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign ex_fwd_ok = ex_valid_q & ex_we_q & ~ex_is_load_q;

  // Combinational operand selection for both sources.
  always_comb begin
    op0_sel = select_operand(bus.id_rs0_addr, bus.rf_p0, ex_fwd_ok, ex_dst_q,
                             bus.ex_result, bus.mem_we, bus.mem_dst_addr, bus.mem_result);
    op1_sel = select_operand(bus.id_rs1_addr, bus.rf_p1, ex_fwd_ok, ex_dst_q,
                             bus.ex_result, bus.mem_we, bus.mem_dst_addr, bus.mem_result);
  end

  // A load-use hazard occurs when a used source reads the non-R0 destination of the load in EX.
  assign hz = bus.id_valid & ex_valid_q & ex_we_q & ex_is_load_q & (ex_dst_q != '0) &
              ((bus.id_rs0_used & (bus.id_rs0_addr == ex_dst_q)) |
               (bus.id_rs1_used & (bus.id_rs1_addr == ex_dst_q)));

  assign bus.rf_re0    = bus.id_valid & bus.id_rs0_used;
  assign bus.rf_re1    = bus.id_valid & bus.id_rs1_used;
  assign bus.stall_out = (hz | bus.stall_in) & ~bus.flush;

  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_we       = ex_we_q;
  assign bus.ex_is_load  = ex_is_load_q;
  assign bus.ex_op0      = ex_op0_q;
  assign bus.ex_op1      = ex_op1_q;
  assign bus.ex_dst_addr = ex_dst_q;
  assign bus.stall_cnt   = stall_cnt_q;

  // Next state for ID/EX, in priority order: flush kills, stall_in holds, a hazard bubbles, otherwise capture.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_we_d      = ex_we_q;
    ex_is_load_d = ex_is_load_q;
    ex_op0_d     = ex_op0_q;
    ex_op1_d     = ex_op1_q;
    ex_dst_d     = ex_dst_q;
    stall_cnt_d  = stall_cnt_q;
    if (bus.flush) begin
      ex_valid_d   = 1'b0;
      ex_we_d      = 1'b0;
      ex_is_load_d = 1'b0;
    end else if (bus.stall_in) begin
      // hold everything; a pending hazard is re-evaluated once the stall releases
    end else if (hz) begin
      ex_valid_d   = 1'b0;
      ex_we_d      = 1'b0;
      ex_is_load_d = 1'b0;
      ex_op0_d     = '0;
      ex_op1_d     = '0;
      ex_dst_d     = '0;
      stall_cnt_d  = sat_inc(stall_cnt_q);
    end else begin
      ex_valid_d   = bus.id_valid;
      ex_we_d      = bus.id_we & bus.id_valid;
      ex_is_load_d = bus.id_is_load & bus.id_valid;
      ex_op0_d     = op0_sel;
      ex_op1_d     = op1_sel;
      ex_dst_d     = bus.id_dst_addr;
    end
  end

  // ID/EX pipeline register and bubble counter, with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_we_q      <= 1'b0;
      ex_is_load_q <= 1'b0;
      ex_op0_q     <= '0;
      ex_op1_q     <= '0;
      ex_dst_q     <= '0;
      stall_cnt_q  <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_we_q      <= ex_we_d;
      ex_is_load_q <= ex_is_load_d;
      ex_op0_q     <= ex_op0_d;
      ex_op1_q     <= ex_op1_d;
      ex_dst_q     <= ex_dst_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_id_operand_stage.sv
// Scoreboard bench for id_operand_stage.
// The driver queues the expected ID/EX state for every clock.
// A negedge monitor pops each entry and compares it with the DUT.
// A second instance with a 2-bit counter exposes saturation.
module tb_id_operand_stage;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  id_operand_if #(.DATA_W(16), .ADDR_W(4), .CNT_W(16)) b  ();
  id_operand_if #(.DATA_W(16), .ADDR_W(4), .CNT_W(2))  bs ();

  id_operand_stage #(.DATA_W(16), .ADDR_W(4), .CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(b));
  id_operand_stage #(.DATA_W(16), .ADDR_W(4), .CNT_W(2))  dut_s (.clk(clk), .rst(rst), .bus(bs));

  assign bs.id_valid     = b.id_valid;
  assign bs.id_rs0_addr  = b.id_rs0_addr;
  assign bs.id_rs1_addr  = b.id_rs1_addr;
  assign bs.id_rs0_used  = b.id_rs0_used;
  assign bs.id_rs1_used  = b.id_rs1_used;
  assign bs.id_dst_addr  = b.id_dst_addr;
  assign bs.id_we        = b.id_we;
  assign bs.id_is_load   = b.id_is_load;
  assign bs.rf_p0        = b.rf_p0;
  assign bs.rf_p1        = b.rf_p1;
  assign bs.ex_result    = b.ex_result;
  assign bs.mem_dst_addr = b.mem_dst_addr;
  assign bs.mem_we       = b.mem_we;
  assign bs.mem_result   = b.mem_result;
  assign bs.stall_in     = b.stall_in;
  assign bs.flush        = b.flush;

  typedef struct {
    string       tag;
    logic        v;
    logic        we;
    logic        ld;
    logic [15:0] op0;
    logic [15:0] op1;
    logic [3:0]  dst;
    logic [15:0] cnt;
    logic [1:0]  scnt;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  int   ecnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: after each clock that carries a scoreboard entry, compare the DUT registers with it.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".ex_valid"},   32'(b.ex_valid),    32'(e.v));
      chk({e.tag, ".ex_we"},      32'(b.ex_we),       32'(e.we));
      chk({e.tag, ".ex_is_load"}, 32'(b.ex_is_load),  32'(e.ld));
      chk({e.tag, ".stall_cnt"},  32'(b.stall_cnt),   32'(e.cnt));
      chk({e.tag, ".sat_cnt"},    32'(bs.stall_cnt),  32'(e.scnt));
      if (e.chk_data) begin
        chk({e.tag, ".ex_op0"},      32'(b.ex_op0),      32'(e.op0));
        chk({e.tag, ".ex_op1"},      32'(b.ex_op1),      32'(e.op1));
        chk({e.tag, ".ex_dst_addr"}, 32'(b.ex_dst_addr), 32'(e.dst));
      end
    end
  end

  task automatic drive_id(input logic v, input logic [3:0] rs0, input logic [3:0] rs1,
                          input logic u0, input logic u1, input logic [3:0] dst,
                          input logic we, input logic ld);
    b.id_valid    = v;
    b.id_rs0_addr = rs0;
    b.id_rs1_addr = rs1;
    b.id_rs0_used = u0;
    b.id_rs1_used = u1;
    b.id_dst_addr = dst;
    b.id_we       = we;
    b.id_is_load  = ld;
  endtask

  task automatic clr_misc();
    b.rf_p0        = '0;
    b.rf_p1        = '0;
    b.ex_result    = '0;
    b.mem_dst_addr = '0;
    b.mem_we       = 1'b0;
    b.mem_result   = '0;
    b.stall_in     = 1'b0;
    b.flush        = 1'b0;
  endtask

  // Check the combinational outputs, clock once, then queue the expected register state.
  task automatic cyc(input string tag, input logic exp_stall, input logic v, input logic we,
                     input logic ld, input logic [15:0] o0, input logic [15:0] o1,
                     input logic [3:0] dst, input logic chk_data);
    exp_t e;
    #1;
    chk({tag, ".stall_out"}, 32'(b.stall_out), 32'(exp_stall));
    chk({tag, ".rf_re0"},    32'(b.rf_re0),    32'(b.id_valid & b.id_rs0_used));
    chk({tag, ".rf_re1"},    32'(b.rf_re1),    32'(b.id_valid & b.id_rs1_used));
    @(posedge clk);
    e.tag = tag; e.v = v; e.we = we; e.ld = ld; e.op0 = o0; e.op1 = o1; e.dst = dst;
    e.cnt = 16'(ecnt);
    e.scnt = (ecnt > 3) ? 2'd3 : 2'(ecnt);
    e.chk_data = chk_data;
    sb.push_back(e);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0);
    clr_misc();
    #1 rst = 1'b1;
    #2;
    chk("reset.ex_valid",  32'(b.ex_valid),  0);
    chk("reset.ex_op0",    32'(b.ex_op0),    0);
    chk("reset.ex_we",     32'(b.ex_we),     0);
    chk("reset.stall_cnt", 32'(b.stall_cnt), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // add R3 <- R1
    drive_id(1, 1, 0, 1, 0, 3, 1, 0); b.rf_p0 = 16'h0011;
    cyc("cap_r3", 0, 1, 1, 0, 16'h0011, 16'h0000, 3, 1);
    // reads R3 (EX forward) and R4 (RF)
    drive_id(1, 3, 4, 1, 1, 6, 1, 0);
    b.rf_p0 = 16'hAAAA; b.rf_p1 = 16'h4444; b.ex_result = 16'h1234;
    cyc("ex_fwd", 0, 1, 1, 0, 16'h1234, 16'h4444, 6, 1);
    // load R5
    clr_misc(); drive_id(1, 0, 0, 0, 0, 5, 1, 1);
    cyc("load_r5", 0, 1, 1, 1, 16'h0000, 16'h0000, 5, 1);
    // R5 used on rs1: bubble
    drive_id(1, 7, 5, 1, 1, 8, 1, 0); b.rf_p0 = 16'h7777; b.rf_p1 = 16'h1111;
    ecnt = 1;
    cyc("hz_bubble", 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1);
    // load data now in MEM
    b.mem_we = 1'b1; b.mem_dst_addr = 4'd5; b.mem_result = 16'hBEEF;
    cyc("mem_fwd", 0, 1, 1, 0, 16'h7777, 16'hBEEF, 8, 1);
    // EX writes R2, MEM writes R2: EX wins
    clr_misc(); drive_id(1, 0, 0, 0, 0, 2, 1, 0);
    cyc("wr_r2", 0, 1, 1, 0, 16'h0000, 16'h0000, 2, 1);
    drive_id(1, 2, 2, 1, 1, 9, 1, 0);
    b.ex_result = 16'h0001; b.mem_we = 1'b1; b.mem_dst_addr = 4'd2; b.mem_result = 16'h0002;
    b.rf_p0 = 16'h9999; b.rf_p1 = 16'h9999;
    cyc("ex_wins", 0, 1, 1, 0, 16'h0001, 16'h0001, 9, 1);
    // MEM only match; this instruction writes R0
    clr_misc(); drive_id(1, 2, 0, 1, 0, 0, 1, 0);
    b.mem_we = 1'b1; b.mem_dst_addr = 4'd2; b.mem_result = 16'h0202; b.rf_p0 = 16'h5555;
    cyc("mem_only", 0, 1, 1, 0, 16'h0202, 16'h0000, 0, 1);
    // R0 reads with EX and MEM both writing R0; this is a load to R4
    clr_misc(); drive_id(1, 0, 0, 1, 1, 4, 1, 1);
    b.ex_result = 16'hFFFF; b.mem_we = 1'b1; b.mem_dst_addr = 4'd0; b.mem_result = 16'hFFFF;
    b.rf_p0 = 16'hFFFF; b.rf_p1 = 16'hFFFF;
    cyc("r0_zero", 0, 1, 1, 1, 16'h0000, 16'h0000, 4, 1);
    // hazard on R4 together with flush
    clr_misc(); drive_id(1, 4, 0, 1, 0, 10, 1, 0); b.flush = 1'b1;
    cyc("hz_flush", 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    // load R11, then stall_in for 3 cycles while a dependent op waits
    clr_misc(); drive_id(1, 3, 0, 1, 0, 11, 1, 1); b.rf_p0 = 16'h3333;
    cyc("cap_load", 0, 1, 1, 1, 16'h3333, 16'h0000, 11, 1);
    drive_id(1, 11, 0, 1, 0, 12, 1, 0); b.stall_in = 1'b1; b.rf_p0 = 16'hDEAD;
    for (int i = 0; i < 3; i++)
      cyc("stall_hold", 1, 1, 1, 1, 16'h3333, 16'h0000, 11, 1);
    b.stall_in = 1'b0;
    ecnt = 2;
    cyc("hz_after_stall", 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1);
    b.mem_we = 1'b1; b.mem_dst_addr = 4'd11; b.mem_result = 16'h0B0B;
    cyc("capture_after", 0, 1, 1, 0, 16'h0B0B, 16'h0000, 12, 1);
    // more load-use pairs bring the count to 5; the 2-bit copy saturates at 3
    for (int i = 0; i < 3; i++) begin
      clr_misc(); drive_id(1, 0, 0, 0, 0, 13, 1, 1);
      cyc("sat_load", 0, 1, 1, 1, 16'h0000, 16'h0000, 13, 1);
      drive_id(1, 0, 13, 0, 1, 14, 1, 0);
      ecnt++;
      cyc("sat_bubble", 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 1);
    end
    clr_misc(); drive_id(1, 0, 0, 0, 0, 14, 1, 0);
    cyc("pre_rst", 0, 1, 1, 0, 16'h0000, 16'h0000, 14, 1);
    // asynchronous reset mid-cycle, away from any clock edge
    drive_id(1, 1, 0, 1, 0, 3, 1, 0);
    #6 rst = 1'b1;
    #1;
    chk("async_rst.ex_valid",   32'(b.ex_valid),    0);
    chk("async_rst.ex_we",      32'(b.ex_we),       0);
    chk("async_rst.ex_is_load", 32'(b.ex_is_load),  0);
    chk("async_rst.ex_dst",     32'(b.ex_dst_addr), 0);
    chk("async_rst.ex_op0",     32'(b.ex_op0),      0);
    chk("async_rst.ex_op1",     32'(b.ex_op1),      0);
    chk("async_rst.stall_cnt",  32'(b.stall_cnt),   0);
    chk("async_rst.sat_cnt",    32'(bs.stall_cnt),  0);
    chk("async_rst.rf_re0",     32'(b.rf_re0),      1);
    chk("sb_drain",             32'(sb.size()),     0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
